// File: rtl/inst_tx.sv
// Serialises a 2*BITS instruction word into two BITS-wide half writes (high, then low).
// Optional INST_TX_GAP_EN inserts one idle GAP cycle between the high and low writes.
module inst_tx #(
    parameter int BITS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2*BITS-1:0] inst_in,
    input  logic              inst_valid,
    output logic              inst_ready,
    output logic [BITS-1:0]   out,
    output logic              set_hi,
    output logic              set_lo,
    output logic              busy,
    output logic              done,
    output logic [1:0]        o_dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HI   = 2'd1;
    localparam logic [1:0] S_LO   = 2'd2;
`ifdef INST_TX_GAP_EN
    localparam logic [1:0] S_GAP  = 2'd3;
`endif

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic [2*BITS-1:0] r_hold;
    logic              w_accept;

    // Valid/ready: a word transfers on a rising edge where inst_valid && inst_ready.
    // inst_ready is a pure state decode, forced low only while reset is held.
    assign inst_ready = rst_n && ((r_state == S_IDLE) || (r_state == S_LO));
    assign w_accept   = inst_valid && inst_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_accept ? S_HI : S_IDLE;
`ifdef INST_TX_GAP_EN
            S_HI:    w_next = S_GAP;
            S_GAP:   w_next = S_LO;
`else
            S_HI:    w_next = S_LO;
`endif
            S_LO:    w_next = w_accept ? S_HI : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_hold  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_hold <= inst_in;
            end
        end
    end

    // All strobes decode registered state/hold only, so nothing from inst_in leaks through.
    always_comb begin
        out    = '0;
        set_hi = 1'b0;
        set_lo = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_HI: begin
                set_hi = 1'b1;
                out    = r_hold[2*BITS-1:BITS];
            end
            S_LO: begin
                set_lo = 1'b1;
                done   = 1'b1;
                out    = r_hold[BITS-1:0];
            end
            default: begin
                out    = '0;
            end
        endcase
    end

    assign busy        = (r_state != S_IDLE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_inst_tx.sv
// Bench for inst_tx: driver pushes expected half-writes into a queue, a negedge monitor
// pops and compares them and feeds a paired instruction-register model.
module tb_inst_tx;

    localparam int BITS = 8;
    localparam int W    = 3 + BITS;
`ifdef INST_TX_GAP_EN
    localparam int LO_OFS = 2;
`else
    localparam int LO_OFS = 1;
`endif

    logic              clk;
    logic              rst_n;
    logic [2*BITS-1:0] inst_in;
    logic              inst_valid;
    logic              inst_ready;
    logic [BITS-1:0]   out;
    logic              set_hi;
    logic              set_lo;
    logic              busy;
    logic              done;
    logic [1:0]        o_dbg_state;

    inst_tx #(.BITS(BITS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inst_in     (inst_in),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .out         (out),
        .set_hi      (set_hi),
        .set_lo      (set_lo),
        .busy        (busy),
        .done        (done),
        .o_dbg_state (o_dbg_state)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    logic [W-1:0]      exp_q[$];
    int                cyc_q[$];
    logic [2*BITS-1:0] word_q[$];
    logic [2*BITS-1:0] model_ir = '0;
    int                checks = 0;
    int                fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every strobe against the queue head, including its cycle
    always @(negedge clk) begin
        logic [W-1:0] e;
        int c;
        if (rst_n) begin
            if (set_hi && set_lo) check("hi_lo_exclusive", 1, 0);
            if (set_hi || set_lo) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {set_hi, set_lo, done, out}, 0);
                end else begin
                    e = exp_q.pop_front();
                    c = cyc_q.pop_front();
                    check("strobe_data", {21'd0, set_hi, set_lo, done, out}, {21'd0, e});
                    check("strobe_cycle", cyc, c);
                end
                if (set_hi) model_ir[2*BITS-1:BITS] = out;
                if (set_lo) model_ir[BITS-1:0] = out;
                if (done) begin
                    if (word_q.size() == 0) check("ir_model_extra", model_ir, 0);
                    else check("ir_model_word", model_ir, word_q.pop_front());
                end
            end else begin
                check("idle_outputs", {done, out}, 0);
                if (cyc_q.size() > 0 && cyc > cyc_q[0]) begin
                    check("missed_strobe", cyc, cyc_q[0]);
                    void'(exp_q.pop_front());
                    void'(cyc_q.pop_front());
                end
            end
        end
    end

    // Driver: leaves inst_valid high until accepted; returns #1 after the accept edge
    task automatic send(input logic [2*BITS-1:0] w);
        int n = 0;
        inst_in    = w;
        inst_valid = 1'b1;
        while (!inst_ready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 10) begin
            check("accept_timeout", n, 0);
        end else begin
            exp_q.push_back({3'b100, w[2*BITS-1:BITS]});
            cyc_q.push_back(cyc + 1);
            exp_q.push_back({3'b011, w[BITS-1:0]});
            cyc_q.push_back(cyc + 1 + LO_OFS);
            word_q.push_back(w);
            @(posedge clk); #1;
            check("ready_low_in_hi", inst_ready, 0);
            check("busy_in_hi", busy, 1);
        end
        inst_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst_n      = 1'b0;
        inst_valid = 1'b0;
        inst_in    = '0;
        #1;
        check("rst_outputs", {inst_ready, busy, set_hi, set_lo, done, out}, 0);
        idle(2);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", inst_ready, 1);
        check("post_rst_busy", busy, 0);

        // Single word
        send(16'h330F);
        idle(4);
        check("idle_busy", busy, 0);

        // Back-to-back: second word taken in LO
        send(16'hA55A);
        send(16'h1234);
        idle(4);

        // Stall: valid held through HI, next word waits for LO; hold must not follow inst_in
        send(16'hFFFF);
        send(16'h5AA5);
        inst_in = 16'hDEAD;
        idle(4);
        check("ready_after_idle", inst_ready, 1);

        // Reset abort during HI
        send(16'hBEEF);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {inst_ready, busy, set_hi, set_lo, done, out}, 0);
        exp_q.delete();
        cyc_q.delete();
        word_q.delete();
        model_ir = '0;
        idle(2);
        rst_n = 1'b1;
        idle(5);
        check("abort_idle_busy", busy, 0);

        // Paired instruction register sequence
        send(16'h330F);
        idle(1);
        send(16'h00FF);
        send(16'h0102);

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        idle(2);
        check("queue_drained", exp_q.size(), 0);
        check("words_drained", word_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/inst_tx.md
INST_TX -- requirements
Module: inst_tx

Interface
REQ-001 SHALL have parameter BITS, default 8: width of one instruction half and of the out bus.
REQ-002 SHALL have port clk  input  1  single system clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port inst_in  input  2*BITS  instruction word to send; [2*BITS-1:BITS] = high half, [BITS-1:0] = low half.
REQ-005 SHALL have port inst_valid  input  1  inst_in holds a word to send.
REQ-006 SHALL have port inst_ready  output  1  block can accept a word this cycle.
REQ-007 SHALL have port out  output  BITS  half-word driven to the instruction register's in bus.
REQ-008 SHALL have port set_hi  output  1  high-half write strobe.
REQ-009 SHALL have port set_lo  output  1  low-half write strobe.
REQ-010 SHALL have port busy  output  1  a word is being transferred (any state other than IDLE).
REQ-011 SHALL have port done  output  1  one-cycle pulse, final half of a word is being written.

Function
REQ-012 SHALL implement states IDLE, HI, LO (plus GAP when configured, REQ-027).
REQ-013 SHALL capture inst_in into an internal hold register on any rising edge where inst_valid && inst_ready.
REQ-014 SHALL drive inst_ready = 1 in IDLE and LO, 0 in HI and GAP; inst_ready depends on state only.
REQ-015 SHALL transition IDLE->HI on accept; IDLE->IDLE otherwise.
REQ-016 SHALL transition HI->LO unconditionally (HI->GAP when configured).
REQ-017 SHALL transition LO->HI on accept (back-to-back), LO->IDLE otherwise.
REQ-018 SHALL in HI assert set_hi=1, set_lo=0, out=hold[2*BITS-1:BITS] for exactly one cycle.
REQ-019 SHALL in LO assert set_lo=1, set_hi=0, out=hold[BITS-1:0], done=1 for exactly one cycle.
REQ-020 SHALL drive out=0, set_hi=0, set_lo=0, done=0 in IDLE (and GAP).
REQ-021 SHALL never assert set_hi and set_lo in the same cycle.
REQ-022 SHALL derive out, set_hi, set_lo, done, busy from registered state/hold only; no combinational path from inst_in/inst_valid.
REQ-023 SHALL have latency: accept at edge k -> set_hi during cycle k..k+1, set_lo during k+1..k+2; sustained throughput one word per 2 cycles.
REQ-024 SHALL ignore inst_in changes while not accepting; hold register alters only on accept.

Reset
REQ-025 SHALL on rst_n=0 immediately force state IDLE, hold=0, out=0, set_hi=0, set_lo=0, done=0, busy=0, inst_ready=0 while asserted (inst_ready=1 after release).
REQ-026 SHALL on reset mid-transfer (HI/LO/GAP) drop the partial word; no strobe asserted after release until a new accept.

Configuration
REQ-027 SHALL when INST_TX_GAP_EN is defined insert a GAP state between HI and LO (one idle cycle, all strobes 0, busy=1, inst_ready=0); throughput one word per 3 cycles.
REQ-028 SHALL when INST_TX_GAP_EN is undefined omit GAP entirely; HI->LO directly.

Verification (BITS=8)
REQ-029 SHALL verify single word: inst_in=16'h330F valid one cycle -> next cycle set_hi=1 out=8'h33; following cycle set_lo=1 done=1 out=8'h0F; then IDLE, out=0.
REQ-030 SHALL verify back-to-back: inst_valid held high with 16'hA55A then 16'h1234 accepted in LO -> strobes hi A5, lo 5A, hi 12, lo 34 on four consecutive cycles.
REQ-031 SHALL verify stall: inst_valid=1 with 16'hFFFF held through HI -> inst_ready=0 in HI, second word not accepted until LO.
REQ-032 SHALL verify reset abort: rst_n pulled low during HI of 16'hBEEF -> all outputs 0 immediately, no set_lo for 8'hEF after release.
REQ-033 SHALL verify with INST_TX_GAP_EN defined: 16'h0102 -> set_hi out 8'h01, one cycle all strobes 0 busy=1, then set_lo out 8'h02 done=1.
REQ-034 SHALL verify with a paired inst_reg model: sequence of 16'h330F, 16'h00FF -> model output equals each word after its done pulse.
